// File: rtl/lsu_mem_requester.sv
// Load/store command FIFO feeding a single-outstanding memory request FSM with in-order responses and a REQ timeout.
// Command accepted at edge T drives store/load from T+1; cmd_ready drops while the FIFO is full; responses hold until rsp_ready.

module lsu_cmd_fifo #(
    parameter int W     = 31,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_pop,
    output logic [W-1:0] out_dat
);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    // Readiness comes from the registered count only, so a full FIFO refuses even when popping.
    assign in_rdy  = (count_q < DEPTH_C) && !reset;
    assign out_vld = (count_q != '0);
    assign out_dat = mem_q[rd_ptr_q];
    assign push    = in_vld && in_rdy;
    assign pop     = out_pop && out_vld;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_dat;
            wr_ptr_d        = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end
endmodule

module lsu_mem_requester #(
    parameter int QDEPTH         = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_is_store,
    input  logic [13:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_is_store,
    output logic        rsp_err,
    output logic        store,
    output logic        load,
    output logic [13:0] addr,
    output logic [15:0] result,
    input  logic        mem_done,
    input  logic [7:0]  datatoinst,
    output logic        busy,
    output logic        err_spurious
);
    typedef struct packed {
        logic        is_store;
        logic [13:0] addr;
        logic [15:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    cmd_t          cmd_in;
    cmd_t          head;
    logic          fifo_vld;
    logic          fifo_pop;

    state_t        state_q, state_d;
    logic          store_q, store_d;
    logic          load_q, load_d;
    logic [13:0]   addr_q, addr_d;
    logic [15:0]   result_q, result_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          rsp_is_store_q, rsp_is_store_d;
    logic          rsp_err_q, rsp_err_d;
    logic          err_spurious_q, err_spurious_d;

    assign cmd_in = '{is_store: cmd_is_store, addr: cmd_addr, wdata: cmd_wdata};

    lsu_cmd_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (cmd_valid),
        .in_rdy  (cmd_ready),
        .in_dat  (cmd_in),
        .out_vld (fifo_vld),
        .out_pop (fifo_pop),
        .out_dat (head)
    );

    always_comb begin
        state_d        = state_q;
        store_d        = store_q;
        load_d         = load_q;
        addr_d         = addr_q;
        result_d       = result_q;
        tmo_d          = tmo_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_data_d     = rsp_data_q;
        rsp_is_store_d = rsp_is_store_q;
        rsp_err_d      = rsp_err_q;
        err_spurious_d = err_spurious_q || (mem_done && (state_q != REQ));
        fifo_pop       = 1'b0;

        case (state_q)
            IDLE: begin
                if (fifo_vld) begin
                    fifo_pop = 1'b1;
                    state_d  = REQ;
                    store_d  = head.is_store;
                    load_d   = !head.is_store;
                    addr_d   = head.addr;
                    result_d = head.is_store ? head.wdata : 16'h0000;
                    tmo_d    = '0;
                end
            end
            REQ: begin
                tmo_d = tmo_q + TW'(1);
                // Completion takes priority over a timeout landing in the same cycle.
                if (mem_done || (tmo_q == TMO_LAST)) begin
                    state_d        = RESP;
                    store_d        = 1'b0;
                    load_d         = 1'b0;
                    rsp_valid_d    = 1'b1;
                    rsp_is_store_d = store_q;
                    rsp_err_d      = !mem_done;
                    rsp_data_d     = (mem_done && load_q) ? datatoinst : 8'h00;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            store_q        <= 1'b0;
            load_q         <= 1'b0;
            addr_q         <= '0;
            result_q       <= '0;
            tmo_q          <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_is_store_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            store_q        <= store_d;
            load_q         <= load_d;
            addr_q         <= addr_d;
            result_q       <= result_d;
            tmo_q          <= tmo_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_is_store_q <= rsp_is_store_d;
            rsp_err_q      <= rsp_err_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    assign store        = store_q;
    assign load         = load_q;
    assign addr         = addr_q;
    assign result       = result_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_is_store = rsp_is_store_q;
    assign rsp_err      = rsp_err_q;
    assign err_spurious = err_spurious_q;
    assign busy         = fifo_vld || (state_q != IDLE);
endmodule
